// File: rtl/chrom_eval_sequencer.sv
// Chromosome evaluation sequencer: walks NUM_VECTORS input vectors and counts per-output mismatches.
// Optional DONE watchdog enabled by defining CHROM_EVAL_TIMEOUT_EN.
module chrom_eval_sequencer #(
  parameter int NUM_VECTORS    = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         start_processing_chrom,
  input  logic         done_processing_feedback,
  output logic         ready_to_process,
  output logic         done_processing_chrom,
  output logic         chrom_load,
  output logic [4:0]   seq_index,
  input  logic [3:0]   circuit_out,
  input  logic [127:0] expected_output,
  output logic [127:0] err_sum,
  output logic         timeout_flag
);

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, SAMPLE, DONE, RELEASE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0][31:0] err_q, err_d;
  logic [3:0]       exp_nib;
  logic [3:0]       miss;

  // {idx,2'b00} keeps the full 7-bit bit offset (idx*4 would overflow 5 bits)
  assign exp_nib = expected_output[{idx_q, 2'b00} +: 4];
  assign miss    = circuit_out ^ exp_nib;

`ifdef CHROM_EVAL_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        wd_expire;
  logic        tflag_q;
  logic        set_tf, clr_tf;

  assign wd_expire = (state_q == DONE) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wd_q    <= '0;
      tflag_q <= 1'b0;
    end else begin
      wd_q <= (state_q == DONE) ? wd_q + 32'd1 : '0;
      if (set_tf)      tflag_q <= 1'b1;
      else if (clr_tf) tflag_q <= 1'b0;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef CHROM_EVAL_TIMEOUT_EN
    set_tf  = 1'b0;
    clr_tf  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // a start seen while feedback is still high belongs to the previous handshake
        if (start_processing_chrom && !done_processing_feedback) begin
          state_d = LOAD;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = '0;
`ifdef CHROM_EVAL_TIMEOUT_EN
          clr_tf  = 1'b1;
`endif
        end
      end
      LOAD: begin
        state_d = start_processing_chrom ? APPLY : IDLE;
      end
      APPLY: begin
        if (!start_processing_chrom) begin
          state_d = IDLE;
        end else if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        if (!start_processing_chrom) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (miss[i] && (err_q[i] != 32'hFFFF_FFFF)) err_d[i] = err_q[i] + 32'd1;
          end
          if (idx_q == 5'(NUM_VECTORS - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = APPLY;
          end
        end
      end
      DONE: begin
        if (done_processing_feedback) begin
          state_d = RELEASE;
`ifdef CHROM_EVAL_TIMEOUT_EN
        end else if (wd_expire) begin
          state_d = IDLE;
          set_tf  = 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (!start_processing_chrom && !done_processing_feedback) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_to_process      = (state_q == IDLE);
  assign done_processing_chrom = (state_q == DONE);
  assign chrom_load            = (state_q == LOAD);
  assign seq_index             = idx_q;
  assign err_sum               = err_q;

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Directed bench for chrom_eval_sequencer (default build, watchdog disabled).
module tb_chrom_eval_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         fb = 1'b0;
  logic [3:0]   circ = 4'h0;
  logic [127:0] exp_out = '0;
  logic         ready, done, load, tflag;
  logic [4:0]   seq;
  logic [127:0] err;

  int checks = 0;
  int failures = 0;
  int n;
  int max_idx;
  bit flag;

  always #5 clk = ~clk;

  chrom_eval_sequencer #(
    .NUM_VECTORS(16), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_clk                 (clk),
    .reset_reset_n           (rst_n),
    .start_processing_chrom  (start),
    .done_processing_feedback(fb),
    .ready_to_process        (ready),
    .done_processing_chrom   (done),
    .chrom_load              (load),
    .seq_index               (seq),
    .circuit_out             (circ),
    .expected_output         (exp_out),
    .err_sum                 (err),
    .timeout_flag            (tflag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
      if (int'(seq) > max_idx) max_idx = int'(seq);
    end
  endtask

  task automatic release_hs();
    fb = 1'b1;
    tick();
    start = 1'b0;
    fb = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_load", load, 0);
    chk("rst_seq", seq, 0);
    chk("rst_err", err, 0);
    chk("rst_tflag", tflag, 0);
    rst_n = 1'b1;
    tick();

    // all-zero evaluation
    start = 1'b1;
    tick();
    chk("A_load", load, 1);
    chk("A_ready", ready, 0);
    tick();
    chk("A_load_drop", load, 0);
    max_idx = 0;
    wait_done(n);
    chk("A_latency", n, 80);
    chk("A_err", err, 0);
    chk("A_max_idx", max_idx, 15);
    circ = 4'hF;
    repeat (5) tick();
    chk("A_done_hold", done, 1);
    chk("A_err_stable", err, 0);
    fb = 1'b1;
    tick();
    chk("A_done_drop", done, 0);
    chk("A_release_notready", ready, 0);
    start = 1'b0;
    fb = 1'b0;
    tick();
    chk("A_idle_ready", ready, 1);

    // stale handshake: start with feedback high is ignored
    start = 1'b1;
    fb = 1'b1;
    repeat (3) tick();
    chk("stale_ready", ready, 1);
    chk("stale_load", load, 0);

    // circuit_out=0101 against all-zero expectations
    circ = 4'b0101;
    fb = 1'b0;
    tick();
    chk("B_load", load, 1);
    tick();
    wait_done(n);
    chk("B_latency", n, 80);
    chk("B_err", err, {32'd0, 32'd16, 32'd0, 32'd16});
    release_hs();
    chk("B_idle", ready, 1);

    // per-vector expectation pattern, run twice for repeatability
    for (int k = 0; k < 16; k++)
      exp_out[4*k +: 4] = {1'b0, (k < 10) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0, (k < 3) ? 1'b1 : 1'b0};
    circ = 4'h0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      tick();
      tick();
      wait_done(n);
      chk($sformatf("C%0d_latency", r), n, 80);
      chk($sformatf("C%0d_err", r), err, {32'd0, 32'd10, 32'd1, 32'd3});
      release_hs();
    end

    // abort when seq_index reaches 7
    exp_out = '0;
    circ = 4'hF;
    start = 1'b1;
    tick();
    n = 0;
    while (seq !== 5'd7 && n < 200) begin
      tick();
      n++;
    end
    chk("D_reach7", seq, 7);
    start = 1'b0;
    tick();
    chk("D_idle", ready, 1);
    chk("D_done", done, 0);
    chk("D_err", err, {32'd7, 32'd7, 32'd7, 32'd7});
    flag = 1'b0;
    repeat (100) begin
      tick();
      if (done !== 1'b0) flag = 1'b1;
    end
    chk("D_no_done", flag, 0);
    chk("D_err_stable", err, {32'd7, 32'd7, 32'd7, 32'd7});

    // asynchronous reset during APPLY of vector 2
    start = 1'b1;
    repeat (12) tick();
    chk("E_pre_seq", seq, 2);
    chk("E_pre_err", err, {32'd2, 32'd2, 32'd2, 32'd2});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("E_ready", ready, 1);
    chk("E_done", done, 0);
    chk("E_load", load, 0);
    chk("E_seq", seq, 0);
    chk("E_err", err, 0);
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (200) begin
      tick();
      if (done !== 1'b0 || ready !== 1'b1) flag = 1'b1;
    end
    chk("E_stay_idle", flag, 0);

    // without the watchdog, DONE waits indefinitely
    circ = 4'h0;
    start = 1'b1;
    tick();
    tick();
    wait_done(n);
    chk("F_latency", n, 80);
    flag = 1'b0;
    repeat (10000) begin
      tick();
      if (done !== 1'b1 || tflag !== 1'b0) flag = 1'b1;
    end
    chk("F_done_held", flag, 0);
    release_hs();
    chk("F_idle", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chrom_eval_sequencer.md
CHROM_EVAL_SEQUENCER -- requirements
Module: chrom_eval_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_VECTORS, 16, evaluation vectors per chromosome (1..32)
  SETTLE_CYCLES, 4, cycles the circuit settles before sampling (1..255)
  TIMEOUT_CYCLES, 1000000, DONE watchdog limit (used only with CHROM_EVAL_TIMEOUT_EN)
REQ-002 Ports SHALL be, one per line:
  clk_clk  in  1  single system clock; all logic rising-edge
  reset_reset_n  in  1  asynchronous, active-low reset
  start_processing_chrom  in  1  HPS request level: chromosome segments valid, evaluate
  done_processing_feedback  in  1  HPS acknowledge level: error sums read
  ready_to_process  out  1  high only in IDLE
  done_processing_chrom  out  1  high only in DONE
  chrom_load  out  1  one-cycle strobe: circuit latches chromosome segments
  seq_index  out  5  current vector index driven to circuit input mux
  circuit_out  in  4  evaluated circuit outputs
  expected_output  in  128  expected nibble per vector; vector k at bits [4k+3:4k]
  err_sum  out  128  four 32-bit mismatch counters; output bit i at [32i+31:32i]
  timeout_flag  out  1  sticky: DONE watchdog expired

Function
REQ-003 FSM states SHALL be IDLE, LOAD, APPLY, SAMPLE, DONE, RELEASE.
REQ-004 IDLE->LOAD when start_processing_chrom=1 and done_processing_feedback=0; start with feedback=1 SHALL be ignored (stale handshake).
REQ-005 LOAD SHALL last one cycle: chrom_load=1, all err_sum cleared to 0, seq_index=0, timeout_flag cleared; then APPLY.
REQ-006 APPLY SHALL hold seq_index for exactly SETTLE_CYCLES cycles, then SAMPLE.
REQ-007 SAMPLE (one cycle): for each i in 0..3, err_sum[i] += (circuit_out[i] != expected_output[4*seq_index+i]), saturating at 32'hFFFFFFFF.
REQ-008 After SAMPLE: if seq_index = NUM_VECTORS-1 -> DONE; else seq_index+1 and APPLY.
REQ-009 With start sampled high in IDLE at cycle N, done_processing_chrom SHALL first be high at cycle N+2+NUM_VECTORS*(SETTLE_CYCLES+1).
REQ-010 DONE->RELEASE when done_processing_feedback=1; done_processing_chrom drops the cycle RELEASE is entered.
REQ-011 RELEASE->IDLE when start_processing_chrom=0 and done_processing_feedback=0.
REQ-012 start_processing_chrom falling in LOAD/APPLY/SAMPLE SHALL abort to IDLE next cycle; err_sum keeps partial values; done never asserted.
REQ-013 err_sum SHALL be stable (not modified) in DONE, RELEASE and IDLE.
REQ-014 seq_index SHALL never exceed NUM_VECTORS-1.

Reset
REQ-015 reset_reset_n=0 SHALL asynchronously force IDLE, ready_to_process=1, done_processing_chrom=0, chrom_load=0, seq_index=0, err_sum=0, timeout_flag=0, all counters 0.
REQ-016 Reset asserted mid-evaluation SHALL discard the evaluation; after release, a new start is required.

Configuration
REQ-017 Macro CHROM_EVAL_TIMEOUT_EN defined: a counter runs in DONE; reaching TIMEOUT_CYCLES without feedback SHALL force IDLE and set timeout_flag=1 (held until next LOAD or reset).
REQ-018 Macro undefined: DONE waits indefinitely; timeout_flag SHALL be tied 0; no watchdog counter synthesized.

Verification
REQ-019 Defaults, expected all 0, circuit_out=4'b0000, start raised at cycle N -> chrom_load pulse at N+1, done at N+82, err_sum all 0.
REQ-020 circuit_out=4'b0101 constant, expected all 0 -> err_sum = {0,16,0,16} (bits 3..0), done at N+82.
REQ-021 Feedback raised 5 cycles after done, then start and feedback dropped -> done low next cycle, RELEASE, IDLE with ready_to_process=1; second start repeats identical results.
REQ-022 Start dropped while seq_index=7 -> IDLE next cycle, done stays 0, err_sum holds counts of vectors 0..6.
REQ-023 Reset pulsed during APPLY -> all outputs at reset values immediately, no done afterwards without new start.
REQ-024 With CHROM_EVAL_TIMEOUT_EN, TIMEOUT_CYCLES=100, no feedback -> IDLE and timeout_flag=1 exactly 100 cycles after done rose; without macro, done held for 10000 cycles.
